// File: rtl/cpu_loader.sv
// Host-link packet loader: parses header/length/payload bytes and streams the
// payload into the CPU instruction or data memory while holding the CPU in reset.
module cpu_loader (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       abort,
  output logic [7:0] cpu_input,
  output logic [4:0] load_address,
  output logic       load,
  output logic       is_instruction,
  output logic       cpu_hold,
  output logic       done,
  output logic       err,
  output logic [7:0] load_count
);

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_DONE} state_t;

  state_t     r_state;
  logic       r_target;
  logic [4:0] r_addr;
  logic [7:0] r_remain;
  logic       r_in_ready;
  logic [7:0] r_cpu_input;
  logic [4:0] r_load_address;
  logic       r_load;
  logic       r_is_instruction;
  logic       r_cpu_hold;
  logic       r_done;
  logic       r_err;
  logic [7:0] r_load_count;

  logic       w_accept;
  logic [4:0] w_next_addr;

  assign w_accept = in_valid & r_in_ready;

  // Data memory is 16 deep, so its address wraps within the low nibble.
  assign w_next_addr = r_target ? (r_addr + 5'd1) : {1'b0, r_addr[3:0] + 4'd1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= S_IDLE;
      r_target         <= 1'b0;
      r_addr           <= 5'd0;
      r_remain         <= 8'd0;
      r_in_ready       <= 1'b0;
      r_cpu_input      <= 8'd0;
      r_load_address   <= 5'd0;
      r_load           <= 1'b0;
      r_is_instruction <= 1'b0;
      r_cpu_hold       <= 1'b0;
      r_done           <= 1'b0;
      r_err            <= 1'b0;
      r_load_count     <= 8'd0;
    end else begin
      r_load <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            if (in_data[6:5] == 2'b00) begin
              r_target   <= in_data[7];
              r_addr     <= in_data[7] ? in_data[4:0] : {1'b0, in_data[3:0]};
              r_cpu_hold <= 1'b1;
              r_state    <= S_LEN;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_LEN: begin
          if (abort) begin
            r_cpu_hold <= 1'b0;
            r_state    <= S_IDLE;
          end else if (w_accept) begin
            r_remain <= (in_data == 8'd0) ? 8'd32 : in_data;
            r_state  <= S_DATA;
          end
        end
        S_DATA: begin
          // Abort wins over a byte accepted in the same cycle.
          if (abort) begin
            r_cpu_hold <= 1'b0;
            r_state    <= S_IDLE;
          end else if (w_accept) begin
            r_load           <= 1'b1;
            r_cpu_input      <= in_data;
            r_load_address   <= r_addr;
            r_is_instruction <= r_target;
            r_load_count     <= r_load_count + 8'd1;
            r_addr           <= w_next_addr;
            r_remain         <= r_remain - 8'd1;
            if (r_remain == 8'd1) begin
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
              r_in_ready <= 1'b0;
              r_state    <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_in_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready       = r_in_ready;
  assign cpu_input      = r_cpu_input;
  assign load_address   = r_load_address;
  assign load           = r_load;
  assign is_instruction = r_is_instruction;
  assign cpu_hold       = r_cpu_hold;
  assign done           = r_done;
  assign err            = r_err;
  assign load_count     = r_load_count;

endmodule

// File: tb/tb_cpu_loader.sv
// Scoreboard bench for cpu_loader: packet driver pushes expected loads, a
// negedge monitor pops and compares every load pulse the loader produces.
module tb_cpu_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       abort;
  logic [7:0] cpu_input;
  logic [4:0] load_address;
  logic       load;
  logic       is_instruction;
  logic       cpu_hold;
  logic       done;
  logic       err;
  logic [7:0] load_count;

  always #5 clk = ~clk;

  cpu_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort), .cpu_input(cpu_input),
    .load_address(load_address), .load(load), .is_instruction(is_instruction),
    .cpu_hold(cpu_hold), .done(done), .err(err), .load_count(load_count)
  );

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
    logic       instr;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int tests = 0, fails = 0;
  int n_loads = 0, err_cycles = 0, exp_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Address of the i-th payload byte, derived directly from the header.
  function automatic logic [4:0] exp_addr(input logic [7:0] hdr, input int i);
    if (hdr[7]) return 5'((int'(hdr[4:0]) + i) % 32);
    else        return 5'((int'(hdr[3:0]) + i) % 16);
  endfunction

  task automatic push_exp(input logic [7:0] hdr, input int i, input logic [7:0] d, input logic last);
    exp_t e;
    e.addr  = exp_addr(hdr, i);
    e.data  = d;
    e.instr = hdr[7];
    e.last  = last;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (err) err_cycles++;
      if (load) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_load: got load at addr %0d data %0h, required none", load_address, cpu_input);
        end else begin
          mon_e = exp_q.pop_front();
          n_loads++;
          check("load_data", cpu_input, mon_e.data);
          check("load_addr", load_address, mon_e.addr);
          check("load_target", is_instruction, mon_e.instr);
          check("done_on_last_load", done, mon_e.last);
          check("hold_during_load", cpu_hold, !mon_e.last);
          check("load_count", load_count, n_loads % 256);
        end
      end else if (done) begin
        tests++;
        fails++;
        $display("FAIL done_without_load: got done=1, required 0");
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic ab);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    abort    = ab;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: in_ready low for %0d cycles, required high", n);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      in_valid = 1'b0;
      abort    = 1'b0;
      in_data  = 8'($urandom);
    end
  endtask

  // step == 0 selects random payload bytes; abort_at < 0 means no abort.
  task automatic send_packet(input logic [7:0] hdr, input logic [7:0] len, input int gap_max,
                             input logic [7:0] base, input logic [7:0] step, input int abort_at);
    int n;
    logic [7:0] d;
    n = (len == 8'd0) ? 32 : int'(len);
    send_byte(hdr, 1'b0);
    if (hdr[6:5] != 2'b00) begin
      exp_err++;
      return;
    end
    idle($urandom_range(0, gap_max));
    send_byte(len, 1'b0);
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, gap_max));
      d = (step == 8'd0) ? 8'($urandom) : 8'(base + step * i);
      if (i == abort_at) begin
        send_byte(d, 1'b1);
        idle(1);
        return;
      end
      push_exp(hdr, i, d, i == n - 1);
      send_byte(d, 1'b0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_cpu_input"}, cpu_input, 0);
    check({tag, "_load_address"}, load_address, 0);
    check({tag, "_is_instruction"}, is_instruction, 0);
    check({tag, "_load"}, load, 0);
    check({tag, "_cpu_hold"}, cpu_hold, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_load_count"}, load_count, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] hdr, len;
    int n, ab;
    reset = 1'b0; in_valid = 1'b0; in_data = 8'd0; abort = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_release", in_ready, 1);

    // Instruction packet, addresses 5..7
    send_packet(8'h85, 8'h03, 0, 8'hA1, 8'h01, -1);
    idle(3);
    check("instr_pkt_count", load_count, 3);
    check("instr_pkt_drained", exp_q.size(), 0);

    // Data packet wrapping 14,15,0
    send_packet(8'h1E, 8'h03, 0, 8'h11, 8'h11, -1);
    idle(3);
    check("data_pkt_drained", exp_q.size(), 0);

    // Length byte 0 means 32 payload bytes
    send_packet(8'h80, 8'h00, 0, 8'h00, 8'h00, -1);
    idle(3);
    check("len0_count", load_count, 38);
    check("len0_drained", exp_q.size(), 0);

    // Bad header
    send_byte(8'hC0, 1'b0);
    exp_err++;
    @(negedge clk);
    in_valid = 1'b0;
    check("bad_hdr_err", err, 1);
    check("bad_hdr_hold", cpu_hold, 0);
    @(negedge clk);
    check("bad_hdr_err_pulse", err, 0);
    check("bad_hdr_hold_after", cpu_hold, 0);
    send_packet(8'h03, 8'h02, 1, 8'h00, 8'h00, -1);
    idle(3);
    check("after_bad_drained", exp_q.size(), 0);

    // Abort with the third payload byte
    send_packet(8'h80, 8'h04, 0, 8'h40, 8'h01, 2);
    check("abort_hold_falls", cpu_hold, 0);
    idle(3);
    check("abort_drained", exp_q.size(), 0);
    check("abort_count", load_count, 42);

    // Reset in the middle of a payload
    send_byte(8'h83, 1'b0);
    send_byte(8'h0A, 1'b0);
    for (int i = 0; i < 3; i++) begin
      push_exp(8'h83, i, 8'(8'hC0 + i), 1'b0);
      send_byte(8'(8'hC0 + i), 1'b0);
    end
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    n_loads  = 0;
    in_valid = 1'b0;
    abort    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_ready", in_ready, 1);
    send_packet(8'h9A, 8'h08, 0, 8'h00, 8'h00, -1);
    idle(3);
    check("midreset_newpkt_count", load_count, 8);
    check("midreset_drained", exp_q.size(), 0);

    // Random packets with gaps, occasional bad headers and aborts
    for (int p = 0; p < 25; p++) begin
      hdr = 8'($urandom);
      if ($urandom_range(0, 5) != 0) hdr[6:5] = 2'b00;
      len = 8'($urandom_range(0, 48));
      n   = (len == 8'd0) ? 32 : int'(len);
      ab  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
      send_packet(hdr, len, 2, 8'h00, 8'h00, ab);
      idle($urandom_range(0, 3));
    end
    idle(5);
    check("final_drained", exp_q.size(), 0);
    check("err_pulses", err_cycles, exp_err);
    check("final_hold", cpu_hold, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_loader.md
CPU_LOADER -- requirements
Module: cpu_loader

Interface
REQ-001 Parameter: none; all widths fixed.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; when low, all state and outputs are forced to reset values at once.
REQ-004 in_data  input  8  byte stream from the host link.
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_ready  output  1  the loader accepts in_data this cycle; a byte is accepted when in_valid and in_ready are both high.
REQ-007 abort  input  1  synchronous abort of the current packet.
REQ-008 cpu_input  output  8  byte driven to the CPU unified load port.
REQ-009 load_address  output  5  CPU load address.
REQ-010 load  output  1  one-cycle CPU load strobe.
REQ-011 is_instruction  output  1  selects the target: 1 = instruction memory, 0 = data memory.
REQ-012 cpu_hold  output  1  active-high hold, used as the CPU reset while a packet is in progress.
REQ-013 done  output  1  one-cycle pulse when a packet completes.
REQ-014 err  output  1  one-cycle pulse when a header is rejected.
REQ-015 load_count  output  8  count of bytes written; wraps from 255 to 0.

Function
REQ-016 Packet format: header byte, then length byte, then payload bytes.
- Header bit 7 = target (1 = instruction, 0 = data).
- Header bits 6:5 = reserved; they must be 00.
- Header bits 4:0 = start address.
- Length byte 0 means 32 payload bytes; any other value N means N payload bytes.
REQ-017 FSM states: IDLE, LEN, DATA, DONE; the reset state is IDLE.
REQ-018 in_ready is high in IDLE, LEN and DATA, and low in DONE.
REQ-019 IDLE, on accepting a header with bits 6:5 = 00:
- latch the target and start address;
- set cpu_hold = 1;
- go to LEN.
REQ-020 IDLE, on accepting a header with bits 6:5 not 00:
- pulse err for one cycle (the cycle after acceptance);
- discard the byte;
- stay in IDLE;
- leave cpu_hold at 0.
REQ-021 LEN, on accepting a byte: latch the remaining count (0 maps to 32) and go to DATA.
REQ-022 DATA, on accepting a byte in cycle N, in cycle N+1:
- load = 1;
- cpu_input = the accepted byte;
- load_address = the current address;
- is_instruction = the latched target.
REQ-023 Outputs cpu_input, load_address and is_instruction are registered and hold their last values while load = 0.
REQ-024 Address rules:
- Instruction target: the address increments modulo 32 after each payload byte (31 is followed by 0).
- Data target: load_address = {0, addr[3:0]}, incrementing modulo 16 (15 is followed by 0); header bit 4 is ignored.
REQ-025 Remaining count decrements on each accepted payload byte; the byte that takes it from 1 to 0 moves the FSM to DONE.
REQ-026 DONE lasts exactly one cycle, in which:
- done = 1;
- cpu_hold = 0;
- the FSM returns to IDLE.
REQ-027 The last payload byte's load pulse coincides with the DONE cycle.
REQ-028 cpu_hold stays high from the cycle after header acceptance until DONE.
REQ-029 Each load pulse increments load_count by 1, wrapping at 256.
REQ-030 abort high in LEN or DATA:
- the FSM returns to IDLE next cycle;
- cpu_hold drops;
- no done pulse is produced;
- a byte accepted in the same cycle is discarded, with no load pulse.
REQ-031 abort in IDLE or DONE is ignored; abort takes priority over a simultaneous byte acceptance.
REQ-032 While in_valid is low, the FSM holds its state indefinitely; gaps between bytes are permitted.

Reset
REQ-033 While reset is low:
- FSM = IDLE;
- cpu_input = 0, load_address = 0, is_instruction = 0;
- load = 0, cpu_hold = 0, done = 0, err = 0;
- load_count = 0;
- in_ready = 0.
REQ-034 Reset asserted mid-packet discards the packet; no further load pulses are issued for it.
REQ-035 After reset is released, in_ready goes high on the first clock edge, and the loader waits for a new header.

Verification
REQ-036 Instruction packet: bytes 0x85, 0x03, 0xA1, 0xA2, 0xA3 sent back-to-back.
- Required: three load pulses at addresses 5, 6, 7 with data A1, A2, A3 and is_instruction = 1.
- Required: done in the cycle of the third load; load_count = 3.
REQ-037 Data packet with wrap: bytes 0x1E, 0x03, 0x11, 0x22, 0x33.
- Required: loads at addresses 14, 15, 0 with is_instruction = 0.
REQ-038 Length 0: header 0x80, length 0x00, then 32 bytes.
- Required: 32 loads at addresses 0..31, then done; load_count = 32.
REQ-039 Bad header 0xC0.
- Required: err pulses once; no load pulses; cpu_hold stays 0; a following valid packet loads normally.
REQ-040 Abort: header 0x80, length 0x04, two payload bytes, then abort high together with a third valid byte.
- Required: exactly two loads; cpu_hold falls; no done pulse.
REQ-041 Reset mid-DATA.
- Required: all outputs return to their reset values immediately, without waiting for a clock edge.
- Required: after release, a new packet loads from its own header address.
